// File: rtl/lsu_gather_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_gather_pkg
//  Description : Shared types and default widths for the gather/scatter LSU
//                and the shared memory it talks to.
//  Revision    : 1.0 - initial release
// ============================================================================
package lsu_gather_pkg;

    // Control states of the gather/scatter sequencer
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } lsu_state_t;

    // Default geometry shared with shared_memory
    localparam int c_DEF_NUM_LANES  = 4;
    localparam int c_DEF_DATA_WIDTH = 8;
    localparam int c_DEF_ADDR_WIDTH = 4;

    // Width of a lane index; never narrower than one bit
    function automatic int lane_idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_gather_lane_picker.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_gather_lane_picker
//  Description : Lowest-set-bit priority encoder used to pick the next lane
//                to issue. o_found is low when the mask is empty.
//  Revision    : 1.0 - initial release
// ============================================================================
module lsu_gather_lane_picker #(
    parameter int NUM_LANES = 4,
    parameter int LANE_W    = 2
) (
    input  logic [NUM_LANES-1:0] i_mask,
    output logic [LANE_W-1:0]    o_idx,
    output logic                 o_found
);

    // Scan from the top down so the lowest set bit is the last one written
    always_comb begin
        o_idx   = '0;
        o_found = 1'b0;
        for (int i = NUM_LANES - 1; i >= 0; i--) begin
            if (i_mask[i]) begin
                o_idx   = LANE_W'(i);
                o_found = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/lsu_gather.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_gather
//  Description : Gather/scatter load-store unit. Accepts one vector request,
//                serializes active lanes onto a single memory port (one lane
//                per cycle), collects load data and returns one response.
//  Revision    : 1.0 - initial release
// ============================================================================
module lsu_gather
    import lsu_gather_pkg::*;
#(
    parameter int NUM_LANES  = c_DEF_NUM_LANES,
    parameter int DATA_WIDTH = c_DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = c_DEF_ADDR_WIDTH
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 i_req_valid,
    output logic                                 o_req_ready,
    input  logic                                 i_req_write,
    input  logic [NUM_LANES-1:0]                 i_req_mask,
    input  logic [NUM_LANES-1:0][ADDR_WIDTH-1:0] i_req_addr,
    input  logic [NUM_LANES-1:0][DATA_WIDTH-1:0] i_req_wdata,
    output logic                                 o_resp_valid,
    input  logic                                 i_resp_ready,
    output logic [NUM_LANES-1:0][DATA_WIDTH-1:0] o_resp_rdata,
    output logic                                 o_mem_read_en,
    output logic                                 o_mem_write_en,
    output logic [ADDR_WIDTH-1:0]                o_mem_addr,
    output logic [DATA_WIDTH-1:0]                o_mem_write_data,
    input  logic [DATA_WIDTH-1:0]                i_mem_read_data
);

    localparam int LANE_W = lane_idx_width(NUM_LANES);

    lsu_state_t                           r_state;
    lsu_state_t                           w_state_nxt;
    logic                                 r_write;
    logic [NUM_LANES-1:0]                 r_mask_rem;
    logic [NUM_LANES-1:0]                 w_mask_rem_nxt;
    logic [NUM_LANES-1:0][ADDR_WIDTH-1:0] r_addr;
    logic [NUM_LANES-1:0][DATA_WIDTH-1:0] r_wdata;
    logic [NUM_LANES-1:0][DATA_WIDTH-1:0] r_rdata;
    logic [LANE_W-1:0]                    r_pend_lane;
    logic                                 r_pend_vld;
    logic [LANE_W-1:0]                    w_lane;
    logic                                 w_found;
    logic                                 w_accept;

    assign w_accept     = (r_state == IDLE) && i_req_valid;
    assign o_resp_rdata = r_rdata;

    lsu_gather_lane_picker #(
        .NUM_LANES (NUM_LANES),
        .LANE_W    (LANE_W)
    ) u_picker (
        .i_mask  (r_mask_rem),
        .o_idx   (w_lane),
        .o_found (w_found)
    );

    // Sequencer state register; reset drops strobes at once since they decode from state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state, handshake and memory-port decode
    always_comb begin
        w_state_nxt      = r_state;
        w_mask_rem_nxt   = r_mask_rem;
        o_req_ready      = 1'b0;
        o_resp_valid     = 1'b0;
        o_mem_read_en    = 1'b0;
        o_mem_write_en   = 1'b0;
        o_mem_addr       = '0;
        o_mem_write_data = '0;
        case (r_state)
            IDLE: begin
                o_req_ready = 1'b1;
                if (i_req_valid) begin
                    w_mask_rem_nxt = i_req_mask;
                    w_state_nxt    = (|i_req_mask) ? ISSUE : RESP;
                end
            end
            ISSUE: begin
                if (w_found) begin
                    o_mem_addr = r_addr[w_lane];
                    if (r_write) begin
                        o_mem_write_en   = 1'b1;
                        o_mem_write_data = r_wdata[w_lane];
                    end else begin
                        o_mem_read_en = 1'b1;
                    end
                end
                w_mask_rem_nxt = r_mask_rem & ~(NUM_LANES'(1) << w_lane);
                if (w_mask_rem_nxt == '0) begin
                    // Loads need one more cycle for the last lane's data to land
                    w_state_nxt = r_write ? RESP : WAIT;
                end
            end
            WAIT: begin
                w_state_nxt = RESP;
            end
            RESP: begin
                o_resp_valid = 1'b1;
                if (i_resp_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Request latch, remaining-lane mask and overlapped load-data capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_write     <= 1'b0;
            r_mask_rem  <= '0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_rdata     <= '0;
            r_pend_lane <= '0;
            r_pend_vld  <= 1'b0;
        end else begin
            r_mask_rem <= w_mask_rem_nxt;
            r_pend_vld <= o_mem_read_en;
            if (o_mem_read_en) begin
                r_pend_lane <= w_lane;
            end
            if (w_accept) begin
                r_write <= i_req_write;
                r_addr  <= i_req_addr;
                r_wdata <= i_req_wdata;
                r_rdata <= '0;
            end else if (r_pend_vld) begin
                r_rdata[r_pend_lane] <= i_mem_read_data;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lsu_gather.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lsu_gather
//  Description : Self-checking bench for lsu_gather with a simple memory,
//                a transaction-level reference model and directed pins.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_lsu_gather;

    logic             clk;
    logic             rst;
    logic             i_req_valid;
    logic             o_req_ready;
    logic             i_req_write;
    logic [3:0]       i_req_mask;
    logic [3:0][3:0]  i_req_addr;
    logic [3:0][7:0]  i_req_wdata;
    logic             o_resp_valid;
    logic             i_resp_ready;
    logic [3:0][7:0]  o_resp_rdata;
    logic             o_mem_read_en;
    logic             o_mem_write_en;
    logic [3:0]       o_mem_addr;
    logic [7:0]       o_mem_write_data;
    logic [7:0]       mem_rd_q;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Memory environment
    logic [7:0] init_mem [16];
    logic [7:0] env_mem  [16];
    bit         env_loaded = 1'b0;

    // Reference model state
    logic [7:0] gold [16];
    bit         gold_loaded = 1'b0;
    bit         busy = 1'b0;
    bit         acc_pend = 1'b0;
    bit         done_pend = 1'b0;
    int         acc_cyc = 0;
    int         exp_n = 0;
    int         exp_lat = 0;
    logic       exp_write = 1'b0;
    logic [3:0] exp_saddr [4];
    logic [7:0] exp_sdata [4];
    logic [31:0] exp_rdata = '0;

    lsu_gather #(
        .NUM_LANES  (4),
        .DATA_WIDTH (8),
        .ADDR_WIDTH (4)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .i_req_valid      (i_req_valid),
        .o_req_ready      (o_req_ready),
        .i_req_write      (i_req_write),
        .i_req_mask       (i_req_mask),
        .i_req_addr       (i_req_addr),
        .i_req_wdata      (i_req_wdata),
        .o_resp_valid     (o_resp_valid),
        .i_resp_ready     (i_resp_ready),
        .o_resp_rdata     (o_resp_rdata),
        .o_mem_read_en    (o_mem_read_en),
        .o_mem_write_en   (o_mem_write_en),
        .o_mem_addr       (o_mem_addr),
        .o_mem_write_data (o_mem_write_data),
        .i_mem_read_data  (mem_rd_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous-read memory: data is valid the cycle after the read strobe
    always @(posedge clk) begin
        if (!env_loaded) begin
            for (int i = 0; i < 16; i++) env_mem[i] <= init_mem[i];
            env_loaded <= 1'b1;
        end else begin
            if (o_mem_write_en) env_mem[o_mem_addr] <= o_mem_write_data;
            if (o_mem_read_en)  mem_rd_q <= env_mem[o_mem_addr];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Compare process: reference model of the whole unit, checked every cycle
    always @(negedge clk) begin
        logic exp_rv;
        int   idx;
        if (!gold_loaded) begin
            for (int i = 0; i < 16; i++) gold[i] = init_mem[i];
            gold_loaded = 1'b1;
        end
        if (rst) begin
            busy = 1'b0; acc_pend = 1'b0; done_pend = 1'b0;
            chk("rst_req_ready",  {31'd0, o_req_ready},    32'd1);
            chk("rst_resp_valid", {31'd0, o_resp_valid},   32'd0);
            chk("rst_rdata",      o_resp_rdata,            32'd0);
            chk("rst_read_en",    {31'd0, o_mem_read_en},  32'd0);
            chk("rst_write_en",   {31'd0, o_mem_write_en}, 32'd0);
            chk("rst_mem_addr",   {28'd0, o_mem_addr},     32'd0);
            chk("rst_mem_wdata",  {24'd0, o_mem_write_data}, 32'd0);
        end else begin
            if (done_pend) begin busy = 1'b0; done_pend = 1'b0; end
            if (acc_pend)  begin busy = 1'b1; acc_cyc = cyc; acc_pend = 1'b0; end
            exp_rv = busy && ((cyc - acc_cyc + 1) >= exp_lat);
            chk("req_ready",  {31'd0, o_req_ready},  {31'd0, !busy});
            chk("resp_valid", {31'd0, o_resp_valid}, {31'd0, exp_rv});
            if (exp_rv) chk("resp_rdata", o_resp_rdata, exp_rdata);
            idx = cyc - acc_cyc;
            if (busy && idx < exp_n) begin
                chk("strobe_rd",   {31'd0, o_mem_read_en},  {31'd0, !exp_write});
                chk("strobe_wr",   {31'd0, o_mem_write_en}, {31'd0, exp_write});
                chk("strobe_addr", {28'd0, o_mem_addr},     {28'd0, exp_saddr[idx]});
                if (exp_write)
                    chk("strobe_wdata", {24'd0, o_mem_write_data}, {24'd0, exp_sdata[idx]});
            end else begin
                chk("idle_rd", {31'd0, o_mem_read_en},  32'd0);
                chk("idle_wr", {31'd0, o_mem_write_en}, 32'd0);
            end
            if (exp_rv && i_resp_ready) done_pend = 1'b1;
            if (i_req_valid && !busy) begin
                acc_pend  = 1'b1;
                exp_write = i_req_write;
                exp_n     = 0;
                exp_rdata = '0;
                for (int l = 0; l < 4; l++) begin
                    if (i_req_mask[l]) begin
                        exp_saddr[exp_n] = i_req_addr[l];
                        exp_sdata[exp_n] = i_req_wdata[l];
                        exp_n++;
                        if (i_req_write) gold[i_req_addr[l]] = i_req_wdata[l];
                        else             exp_rdata[l*8 +: 8] = gold[i_req_addr[l]];
                    end
                end
                exp_lat = (exp_n == 0) ? 1 : (i_req_write ? exp_n + 1 : exp_n + 2);
            end
        end
    end

    // One transaction; called at posedge+2 with the unit idle
    task automatic txn(input logic w, input logic [3:0] m, input logic [15:0] a,
                       input logic [31:0] d, input int hold,
                       output logic [31:0] rd, output int lat);
        i_req_valid  = 1'b1;
        i_req_write  = w;
        i_req_mask   = m;
        i_req_addr   = a;
        i_req_wdata  = d;
        i_resp_ready = 1'b0;
        @(posedge clk); #2;
        i_req_valid = 1'b0;
        lat = 1;
        while (!o_resp_valid && lat < 40) begin
            @(posedge clk); #2;
            lat++;
        end
        chk("resp_timeout", {31'd0, o_resp_valid}, 32'd1);
        rd = o_resp_rdata;
        for (int i = 0; i < hold; i++) begin
            // A request offered while the response is held must be ignored
            i_req_valid = (i == 1);
            i_req_write = $urandom_range(0, 1);
            i_req_mask  = 4'($urandom_range(1, 15));
            i_req_addr  = 16'($urandom);
            i_req_wdata = $urandom;
            @(posedge clk); #2;
            chk("hold_rdata", o_resp_rdata, rd);
        end
        i_req_valid  = 1'b0;
        i_resp_ready = 1'b1;
        @(posedge clk); #2;
        i_resp_ready = 1'b0;
    endtask

    initial begin
        logic [31:0] rd;
        int          lat;
        for (int i = 0; i < 16; i++) init_mem[i] = 8'($urandom);
        init_mem[0] = 8'd5; init_mem[1] = 8'd3; init_mem[2] = 8'd7; init_mem[3] = 8'd2;
        rst = 1'b1; i_req_valid = 1'b0; i_req_write = 1'b0; i_req_mask = '0;
        i_req_addr = '0; i_req_wdata = '0; i_resp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        @(posedge clk); #2;

        // Four-lane gather from addresses 0..3
        txn(1'b0, 4'b1111, 16'h3210, 32'h0, 0, rd, lat);
        chk("tp1_rdata", rd, 32'h02070305);
        chk("tp1_lat", lat, 32'd6);

        // Sparse scatter to 8 and 9
        txn(1'b1, 4'b0101, 16'h0908, 32'h00220011, 0, rd, lat);
        chk("tp2_lat", lat, 32'd3);
        chk("tp2_rdata", rd, 32'd0);
        chk("tp2_m8", {24'd0, env_mem[8]}, 32'h11);
        chk("tp2_m9", {24'd0, env_mem[9]}, 32'h22);

        // All lanes store to one address: highest lane wins
        txn(1'b1, 4'b1111, 16'h8888, 32'h04030201, 0, rd, lat);
        chk("tp3_m8", {24'd0, env_mem[8]}, 32'h04);
        chk("tp3_lat", lat, 32'd5);

        // Empty mask
        txn(1'b0, 4'b0000, 16'h1234, 32'h0, 0, rd, lat);
        chk("tp4_lat", lat, 32'd1);
        chk("tp4_rdata", rd, 32'd0);

        // Response held for five cycles with a stray request in the window
        txn(1'b0, 4'b1010, 16'h3210, 32'h0, 5, rd, lat);
        chk("tp5_rdata", rd, 32'h02000300);

        // Reset during the second issue cycle of a four-lane load
        i_req_valid = 1'b1; i_req_write = 1'b0; i_req_mask = 4'b1111;
        i_req_addr = 16'h3210; i_req_wdata = '0;
        @(posedge clk); #2;
        i_req_valid = 1'b0;
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        chk("tp6_rd_drop", {31'd0, o_mem_read_en}, 32'd0);
        chk("tp6_wr_drop", {31'd0, o_mem_write_en}, 32'd0);
        @(posedge clk); #2;
        rst = 1'b0;
        #1;
        chk("tp6_req_ready", {31'd0, o_req_ready}, 32'd1);
        chk("tp6_resp_valid", {31'd0, o_resp_valid}, 32'd0);
        @(posedge clk); #2;
        txn(1'b0, 4'b1111, 16'h3210, 32'h0, 0, rd, lat);
        chk("tp6_after_rdata", rd, 32'h02070305);
        chk("tp6_after_lat", lat, 32'd6);

        // Randomized traffic against the model
        for (int t = 0; t < 60; t++) begin
            txn(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 16'($urandom),
                $urandom, $urandom_range(0, 3), rd, lat);
        end

        repeat (3) @(posedge clk);
        #2;
        for (int i = 0; i < 16; i++) chk("final_mem", {24'd0, env_mem[i]}, {24'd0, gold[i]});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global watchdog
    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
